// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: command/response ports of both requesters plus the ALU hookup.
interface alu_req_arbiter_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic rsp_zero, rsp_err;
  logic [2:0] alu_control;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic alu_zero, busy, grant_id;
  logic [CNT_W-1:0] op_count;
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output alu_control, alu_a, alu_b, busy, grant_id, op_count
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input alu_control, alu_a, alu_b, busy, grant_id, op_count
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters.
module alu_req_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  alu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic ptr, sel, accept, hs, legal, grant, zero, err;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, result;
  logic [CNT_W-1:0] count;
  always_comb begin
    sel = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
    accept = rst_n && state == IDLE && (bus.req0_valid || bus.req1_valid);
    hs = state == RESP && (grant ? bus.rsp1_ready : bus.rsp0_ready);
    legal = op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Priority pointer only moves on a completed response, so contention alternates.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      op <= '0;
      a <= '0;
      b <= '0;
      grant <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      err <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= sel ? bus.req1_op : bus.req0_op;
        a <= sel ? bus.req1_a : bus.req0_a;
        b <= sel ? bus.req1_b : bus.req0_b;
        grant <= sel;
      end
      if (state == EXEC) begin
        result <= legal ? bus.alu_result : '0;
        zero <= legal && bus.alu_zero;
        err <= !legal;
      end
      if (hs) begin
        ptr <= !grant;
        count <= count + 1'b1;
      end
    end
  assign bus.req0_ready = accept && !sel;
  assign bus.req1_ready = accept && sel;
  assign bus.rsp0_valid = state == RESP && !grant;
  assign bus.rsp1_valid = state == RESP && grant;
  assign bus.rsp_result = result;
  assign bus.rsp_zero = zero;
  assign bus.rsp_err = err;
  assign bus.alu_control = op;
  assign bus.alu_a = a;
  assign bus.alu_b = b;
  assign bus.busy = state != IDLE;
  assign bus.grant_id = grant;
  assign bus.op_count = count;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed table, contention/stall/reset sequences and random traffic vs a transaction model.
module tb_alu_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0, bad = 0;
  int mptr = 0, mcnt = 0;
  logic pv [2];
  logic rr [2];
  logic [2:0] pop [2];
  logic [31:0] pa [2], pb [2];
  logic [31:0] env_r;
  typedef struct {
    bit id;
    logic [2:0] op;
    logic [31:0] a, b, r;
    logic z, e;
  } vec_t;
  vec_t tv [9];

  alu_req_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus ();
  alu_req_arbiter #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Stand-in ALU; illegal codes produce junk so the arbiter must mask them.
  always_comb begin
    case (bus.alu_control)
      3'b000: env_r = bus.alu_a & bus.alu_b;
      3'b001: env_r = bus.alu_a | bus.alu_b;
      3'b010: env_r = bus.alu_a + bus.alu_b;
      3'b110: env_r = bus.alu_a - bus.alu_b;
      3'b111: env_r = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: env_r = bus.alu_a ^ bus.alu_b ^ 32'h5a5a_0001;
    endcase
    bus.alu_result = env_r;
    bus.alu_zero = (bus.alu_control inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111}) ? env_r == 32'b0 : 1'b1;
  end

  function automatic logic [33:0] ref_rsp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x + y;
      3'b110: r = x - y;
      3'b111: r = {31'b0, $signed(x) < $signed(y)};
      default: return {2'b10, 32'b0};
    endcase
    return {1'b0, r == 32'b0, r};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply();
    bus.req0_valid = pv[0]; bus.req0_op = pop[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
    bus.req1_valid = pv[1]; bus.req1_op = pop[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
    bus.rsp0_ready = rr[0]; bus.rsp1_ready = rr[1];
  endtask

  task automatic load(input int id, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    pv[id] = 1'b1; pop[id] = o; pa[id] = x; pb[id] = y;
  endtask

  task automatic load_rand(input int id);
    logic [31:0] x;
    x = $urandom;
    load(id, 3'($urandom_range(0, 7)), x, ($urandom_range(0, 3) == 0) ? x : $urandom);
  endtask

  task automatic check_reset(input string name);
    check({name, "_valid"}, {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready}, 0);
    check({name, "_state"}, {bus.busy, bus.grant_id, bus.alu_control}, 0);
    check({name, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 0);
    check({name, "_rsp"}, {bus.rsp_err, bus.rsp_zero, bus.rsp_result}, 0);
    check({name, "_count"}, bus.op_count, 0);
  endtask

  // One full transaction: wait for accept, check arbitration, latency, hold behaviour and count.
  task automatic serve(input int hold, output int win, output logic [33:0] got);
    int n = 0;
    int ew;
    logic [2:0] o;
    logic [31:0] xa, xb;
    logic [33:0] x;
    win = -1;
    got = '0;
    apply();
    #1;
    while (!(bus.req0_ready || bus.req1_ready)) begin
      if (n == 20) begin
        check("accept_timeout", 0, 1);
        return;
      end
      tick();
      apply();
      #1;
      n++;
    end
    check("one_ready", bus.req0_ready & bus.req1_ready, 0);
    ew = (pv[0] && pv[1]) ? mptr : (pv[1] ? 1 : 0);
    win = bus.req1_ready ? 1 : 0;
    check("grant", win, ew);
    o = pop[win]; xa = pa[win]; xb = pb[win];
    x = ref_rsp(o, xa, xb);
    tick();
    pv[win] = 1'b0;
    apply();
    #1;
    check("exec_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("exec_busy_gid", {bus.busy, bus.grant_id}, {1'b1, 1'(win)});
    check("exec_alu_ctl", bus.alu_control, o);
    check("exec_alu_ab", {bus.alu_a, bus.alu_b}, {xa, xb});
    check("exec_ready", bus.req0_ready | bus.req1_ready, 0);
    for (int k = 0; k <= hold; k++) begin
      tick();
      #1;
      if (k == 0) got = {bus.rsp_err, bus.rsp_zero, bus.rsp_result};
      check("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, (win == 1) ? 2 : 1);
      check("rsp_data", {bus.rsp_err, bus.rsp_zero, bus.rsp_result}, x);
      check("rsp_alu_hold", {bus.alu_control, bus.alu_a, bus.alu_b}, {o, xa, xb});
      check("rsp_ready_block", bus.req0_ready | bus.req1_ready, 0);
    end
    rr[win] = 1'b1;
    apply();
    tick();
    rr[win] = 1'b0;
    apply();
    mptr = 1 - win;
    mcnt++;
    #1;
    check("op_count", bus.op_count, mcnt & 16'hffff);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, c0, c1;
    logic [33:0] g;
    tv[0] = '{1'b0, 3'b000, 32'h14071757, 32'h14071758, 32'h14071750, 1'b0, 1'b0};
    tv[1] = '{1'b1, 3'b110, 32'h14071757, 32'h14071757, 32'h00000000, 1'b1, 1'b0};
    tv[2] = '{1'b1, 3'b111, 32'h14071757, 32'h14071758, 32'h00000001, 1'b0, 1'b0};
    tv[3] = '{1'b1, 3'b111, 32'h14071758, 32'h14071757, 32'h00000000, 1'b1, 1'b0};
    tv[4] = '{1'b0, 3'b011, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, 1'b1};
    tv[5] = '{1'b0, 3'b010, 32'h00000005, 32'h00000007, 32'h0000000c, 1'b0, 1'b0};
    tv[6] = '{1'b1, 3'b001, 32'hf0f00000, 32'h0000000f, 32'hf0f0000f, 1'b0, 1'b0};
    tv[7] = '{1'b0, 3'b100, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
    tv[8] = '{1'b1, 3'b101, 32'hffffffff, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; rr[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
    end
    rst_n = 1'b0;
    apply();
    repeat (2) tick();
    check_reset("reset");
    rst_n = 1'b1;
    // Contention from the first cycle out of reset: grants must alternate.
    load_rand(0);
    load_rand(1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      serve(0, w, g);
      check("alternate", w, i % 2);
      if (w == 0) begin
        c0++;
        if (c0 < 4) load_rand(0);
      end else begin
        c1++;
        if (c1 < 4) load_rand(1);
      end
    end
    check("alt_count", bus.op_count, 8);
    for (int i = 0; i < 9; i++) begin
      load(int'(tv[i].id), tv[i].op, tv[i].a, tv[i].b);
      serve(i % 3, w, g);
      check("tbl_id", w, tv[i].id);
      check("tbl_rsp", g, {tv[i].e, tv[i].z, tv[i].r});
    end
    // Stalled response keeps requester 1 locked out for five cycles.
    load(0, 3'b010, 32'hffffffff, 32'h00000001);
    load(1, 3'b000, 32'hff00ff00, 32'h0ff00ff0);
    serve(5, w, g);
    check("stall_id", w, 0);
    check("stall_rsp", g, {2'b01, 32'h0});
    serve(0, w, g);
    check("stall_next_id", w, 1);
    check("stall_next_rsp", g, {2'b00, 32'h0f000f00});
    // Reset in EXEC after requester 1 was accepted while it held priority.
    load(0, 3'b001, 32'h1, 32'h2);
    serve(0, w, g);
    load(1, 3'b010, 32'h3, 32'h4);
    apply();
    #1;
    check("rst_accept", {bus.req0_ready, bus.req1_ready}, 2'b01);
    tick();
    check("rst_in_exec", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    pv[1] = 1'b0;
    apply();
    repeat (2) tick();
    rst_n = 1'b1;
    mptr = 0;
    mcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("post_reset_quiet", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 0);
    end
    load(0, 3'b110, 32'h10, 32'h3);
    load(1, 3'b111, 32'h80000000, 32'h1);
    serve(0, w, g);
    check("post_reset_prio", w, 0);
    check("post_reset_rsp", g, {2'b00, 32'h0000000d});
    serve(1, w, g);
    check("post_reset_slt", g, {2'b00, 32'h00000001});
    for (int i = 0; i < 80; i++) begin
      for (int id = 0; id < 2; id++)
        if (!pv[id] && $urandom_range(0, 1) == 1) load_rand(id);
      if (!pv[0] && !pv[1]) load_rand($urandom_range(0, 1));
      serve($urandom_range(0, 3), w, g);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
